// File: rtl/stall_flush_unit.sv
// rtl/stall_flush_unit.sv - pipeline interlock, redirect flush and mult/div busy tracking
module stall_flush_unit #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    input  logic [4:0]       Write_Reg_E,
    input  logic [4:0]       Write_Reg_M,
    input  logic             Reg_Write_E,
    input  logic             Reg_Write_M,
    input  logic             Mem_To_Reg_E,
    input  logic             Mem_To_Reg_M,
    input  logic             Branch_D,
    input  logic             Jump_D,
    input  logic             PC_Src_D,
    input  logic             Md_Start_E,
    input  logic             Md_Div_E,
    input  logic             Md_Read_D,
    input  logic             Md_Start_D,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Md_Busy,
    output logic             Md_Done,
    output logic             Md_Error,
    output logic [CNT_W-1:0] Stall_Count
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    md_state_e        state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic match_e, match_m;
    logic lw_stall, br_stall, md_busy_eff, md_stall, stall;

    assign match_e = (Write_Reg_E != 5'd0) && ((Write_Reg_E == Rs_D) || (Write_Reg_E == Rt_D));
    assign match_m = (Write_Reg_M != 5'd0) && ((Write_Reg_M == Rs_D) || (Write_Reg_M == Rt_D));

    assign lw_stall    = Reg_Write_E && Mem_To_Reg_E && match_e;
    // ALU results in E and loads in M cannot reach the D-stage comparator in time
    assign br_stall    = Branch_D && ((Reg_Write_E && match_e) ||
                                      (Reg_Write_M && Mem_To_Reg_M && match_m));
    assign md_busy_eff = (state_q == MD_BUSY) || Md_Start_E;
    assign md_stall    = md_busy_eff && (Md_Read_D || Md_Start_D);
    assign stall       = lw_stall || br_stall || md_stall;

    assign Stall_F     = stall;
    assign Stall_D     = stall;
    assign Flush_E     = stall;
    assign Flush_D     = (PC_Src_D || Jump_D) && !stall;
    assign Md_Busy     = md_busy_eff;
    assign Md_Done     = done_q;
    assign Md_Error    = error_q;
    assign Stall_Count = stall_count_q;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        done_d        = 1'b0;
        error_d       = error_q;
        stall_count_d = stall_count_q;
        case (state_q)
            MD_IDLE: begin
                if (Md_Start_E) begin
                    count_d = Md_Div_E ? DIV_LOAD : MUL_LOAD;
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                // A start while busy is dropped; the running operation keeps its count
                if (Md_Start_E) begin
                    error_d = 1'b1;
                end
                if (count_q <= CW'(1)) begin
                    state_d = MD_IDLE;
                    count_d = '0;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= MD_IDLE;
            count_q       <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            done_q        <= done_d;
            error_q       <= error_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule
